viterbi_acs_sched: RTL and testbench

//  Sequencer for the 64-state BMC/ACS datapath of the Viterbi decoder.
//  - Accepts one received 2-bit symbol pair per trellis stage over a valid/ready handshake.
//  - Time-multiplexes N_BFLY butterfly (BMC+ACS) units across all state groups.
//  - Ping-pongs the path-metric banks and schedules metric normalisation.
//  - Writes survivor decisions, then hands the finished frame to traceback.

---
 rtl/viterbi_acs_sched.sv | 140 ++++++++++++++
 tb/tb_viterbi_acs_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_acs_sched.sv
// Viterbi BMC/ACS sequencer: walks butterfly groups per trellis stage,
// ping-pongs path-metric banks, schedules normalisation, hands off to traceback.
module viterbi_acs_sched #(
  parameter  int N_STATES = 64,
  parameter  int N_BFLY   = 8,
  parameter  int LEN_W    = 10,
  localparam int G        = N_STATES / (2 * N_BFLY),
  localparam int GRP_W    = (G > 1) ? $clog2(G) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             sym_valid,
  input  logic [1:0]       sym_pair,
  output logic             sym_ready,
  output logic [1:0]       rx_pair,
  output logic [GRP_W-1:0] grp_idx,
  output logic             acs_en,
  output logic             pm_init,
  output logic             pm_rd_bank,
  output logic             norm_en,
  input  logic             pm_over,
  output logic             dec_we,
  output logic [LEN_W-1:0] dec_stage,
  output logic             tb_start,
  input  logic             tb_busy,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_SYM,
    RUN,
    SWAP,
    TB_REQ
  } state_t;

  state_t           state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] stage_q, stage_d;
  logic [1:0]       rx_q, rx_d;
  logic             bank_q, bank_d;
  logic             norm_q, norm_d;
  logic             ovf_q, ovf_d;
  logic             grp_last;

  assign grp_last = (grp_q == GRP_W'(G - 1));

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    len_d   = len_q;
    stage_d = stage_q;
    rx_d    = rx_q;
    bank_d  = bank_q;
    norm_d  = norm_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start && (frame_len != '0)) begin
          state_d = INIT;
          len_d   = frame_len;
          stage_d = '0;
          grp_d   = '0;
          norm_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      INIT: begin
        grp_d = grp_last ? '0 : grp_q + 1'b1;
        if (grp_last) state_d = WAIT_SYM;
      end
      WAIT_SYM: begin
        if (sym_valid) begin
          rx_d    = sym_pair;
          state_d = RUN;
        end
      end
      RUN: begin
        ovf_d = ovf_q | pm_over;
        grp_d = grp_last ? '0 : grp_q + 1'b1;
        if (grp_last) state_d = SWAP;
      end
      SWAP: begin
        bank_d = ~bank_q;
        norm_d = ovf_q;
        ovf_d  = 1'b0;
        if (stage_q == len_q - LEN_W'(1)) begin
          state_d = TB_REQ;
        end else begin
          stage_d = stage_q + 1'b1;
          state_d = WAIT_SYM;
        end
      end
      TB_REQ: begin
        if (!tb_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      len_q   <= '0;
      stage_q <= '0;
      rx_q    <= 2'b00;
      bank_q  <= 1'b0;
      norm_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      len_q   <= len_d;
      stage_q <= stage_d;
      rx_q    <= rx_d;
      bank_q  <= bank_d;
      norm_q  <= norm_d;
      ovf_q   <= ovf_d;
    end
  end

  // Strobes decode straight off the state flop so reset clears them at once.
  assign sym_ready  = (state_q == WAIT_SYM);
  assign acs_en     = (state_q == RUN);
  assign dec_we     = (state_q == RUN);
  assign pm_init    = (state_q == INIT);
  assign busy       = (state_q != IDLE);
  assign tb_start   = (state_q == TB_REQ) && !tb_busy;
  assign rx_pair    = rx_q;
  assign grp_idx    = grp_q;
  assign pm_rd_bank = bank_q;
  assign norm_en    = norm_q;
  assign dec_stage  = stage_q;

endmodule

// File: tb/tb_viterbi_acs_sched.sv
// Directed bench for viterbi_acs_sched (N_BFLY=8, G=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_viterbi_acs_sched;

  localparam int LEN_W = 10;
  localparam int GRP_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             frame_start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             sym_valid = 1'b0;
  logic [1:0]       sym_pair = 2'b00;
  logic             sym_ready;
  logic [1:0]       rx_pair;
  logic [GRP_W-1:0] grp_idx;
  logic             acs_en;
  logic             pm_init;
  logic             pm_rd_bank;
  logic             norm_en;
  logic             pm_over = 1'b0;
  logic             dec_we;
  logic [LEN_W-1:0] dec_stage;
  logic             tb_start;
  logic             tb_busy = 1'b0;
  logic             busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  viterbi_acs_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .frame_len  (frame_len),
    .sym_valid  (sym_valid),
    .sym_pair   (sym_pair),
    .sym_ready  (sym_ready),
    .rx_pair    (rx_pair),
    .grp_idx    (grp_idx),
    .acs_en     (acs_en),
    .pm_init    (pm_init),
    .pm_rd_bank (pm_rd_bank),
    .norm_en    (norm_en),
    .pm_over    (pm_over),
    .dec_we     (dec_we),
    .dec_stage  (dec_stage),
    .tb_start   (tb_start),
    .tb_busy    (tb_busy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int len);
    frame_start = 1'b1;
    frame_len   = LEN_W'(len);
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("init_pm_init", pm_init, 1);
      chk("init_grp", grp_idx, k);
      chk("init_norm", norm_en, 0);
      chk("init_ready", sym_ready, 0);
      chk("init_busy", busy, 1);
      @(negedge clk);
    end
  endtask

  // Entered on the falling edge of a WAIT_SYM cycle, leaves one edge after SWAP.
  task automatic do_stage(input logic [1:0] pair, input int stg,
                          input logic bank, input logic norm,
                          input int ovf_at, input int bp, input int fs_at);
    chk("wait_ready", sym_ready, 1);
    chk("wait_acs", acs_en, 0);
    chk("wait_stage", dec_stage, stg);
    chk("wait_bank", pm_rd_bank, bank);
    chk("wait_norm", norm_en, norm);
    if (bp > 0) begin
      sym_valid = 1'b0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_ready", sym_ready, 1);
        chk("bp_acs", acs_en, 0);
        chk("bp_stage", dec_stage, stg);
      end
    end
    sym_valid = 1'b1;
    sym_pair  = pair;
    @(negedge clk);
    sym_pair = ~pair;
    for (int k = 0; k < 4; k++) begin
      chk("run_acs", acs_en, 1);
      chk("run_we", dec_we, 1);
      chk("run_grp", grp_idx, k);
      chk("run_rx", rx_pair, pair);
      chk("run_stage", dec_stage, stg);
      chk("run_norm", norm_en, norm);
      chk("run_bank", pm_rd_bank, bank);
      chk("run_ready", sym_ready, 0);
      pm_over     = (k == ovf_at);
      frame_start = (k == fs_at);
      frame_len   = LEN_W'(5);
      @(negedge clk);
    end
    pm_over     = 1'b0;
    frame_start = 1'b0;
    chk("swap_acs", acs_en, 0);
    chk("swap_we", dec_we, 0);
    chk("swap_busy", busy, 1);
    chk("swap_ready", sym_ready, 0);
    chk("swap_bank", pm_rd_bank, bank);
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sym_ready, 0);
    chk("rst_acs", acs_en, 0);
    chk("rst_grp", grp_idx, 0);
    chk("rst_stage", dec_stage, 0);
    chk("rst_rx", rx_pair, 0);
    chk("rst_bank", pm_rd_bank, 0);
    chk("rst_tb_start", tb_start, 0);
    chk("rst_pm_init", pm_init, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-length frame is ignored
    frame_start = 1'b1;
    frame_len   = '0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("len0_busy", busy, 0);
    chk("len0_pm_init", pm_init, 0);
    @(negedge clk);
    chk("len0_busy2", busy, 0);

    // frame 1: len 3, overflow in stage 0, restart attempt mid-RUN
    start_frame(3);
    do_stage(2'b01, 0, 1'b0, 1'b0, 2, 0, -1);
    do_stage(2'b10, 1, 1'b1, 1'b1, -1, 0, 1);
    do_stage(2'b11, 2, 1'b0, 1'b0, -1, 0, -1);
    sym_valid = 1'b0;
    chk("f1_tb_start", tb_start, 1);
    chk("f1_tb_busy", busy, 1);
    chk("f1_end_bank", pm_rd_bank, 1);
    @(negedge clk);
    chk("f1_idle_busy", busy, 0);
    chk("f1_idle_tb", tb_start, 0);
    chk("f1_idle_ready", sym_ready, 0);

    // frame 2: back-pressure, traceback busy, overflow in last stage
    start_frame(2);
    do_stage(2'b10, 0, 1'b1, 1'b0, -1, 5, -1);
    tb_busy = 1'b1;
    do_stage(2'b01, 1, 1'b0, 1'b0, 0, 0, -1);
    sym_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("tbw_start", tb_start, 0);
      chk("tbw_busy", busy, 1);
      @(negedge clk);
    end
    chk("f2_norm", norm_en, 1);
    tb_busy = 1'b0;
    #1;
    chk("f2_tb_start", tb_start, 1);
    @(negedge clk);
    chk("f2_idle_busy", busy, 0);
    chk("f2_idle_tb", tb_start, 0);

    // frame 3: norm cleared on INIT, then reset mid-RUN at grp 2
    start_frame(2);
    sym_valid = 1'b1;
    sym_pair  = 2'b11;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_grp", grp_idx, 2);
    chk("mid_acs", acs_en, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_acs", acs_en, 0);
    chk("arst_we", dec_we, 0);
    chk("arst_grp", grp_idx, 0);
    chk("arst_rx", rx_pair, 0);
    sym_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_ready", sym_ready, 0);
    chk("post_bank", pm_rd_bank, 0);
    chk("post_norm", norm_en, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
